// File: rtl/picoctrl_loader_pkg.sv
// rtl/picoctrl_loader_pkg.sv - types and constants for picoctrl_loader
// Wraps the shared picoload_defs.v constants and provides the FSM state type.
package picoctrl_loader_pkg;

`include "picoload_defs.v"

    typedef enum logic [2:0] {
        ST_IDLE    = PL_ST_IDLE,
        ST_LOAD_HI = PL_ST_LOAD_HI,
        ST_LOAD_LO = PL_ST_LOAD_LO,
        ST_CHECK   = PL_ST_CHECK,
        ST_RUN     = PL_ST_RUN,
        ST_ERROR   = PL_ST_ERROR
    } state_t;

endpackage

// File: rtl/picoctrl_loader_ram.sv
// rtl/picoctrl_loader_ram.sv - instruction RAM for the PicoCTRL loader
// Module picoload_ram: 2^ADDR_W x WORD_W storage, contents not reset.
// Ports:
//   clk           - write clock
//   we/waddr/wdata - synchronous write port
//   raddr/rdata   - asynchronous read port
module picoload_ram #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/picoload_defs.v
// rtl/picoload_defs.v - shared constants for the PicoCTRL program loader
// Included into picoctrl_loader_pkg; holds the state encodings, word count,
// byte order and checksum width used by the loader.

localparam logic [2:0] PL_ST_IDLE    = 3'd0;
localparam logic [2:0] PL_ST_LOAD_HI = 3'd1;
localparam logic [2:0] PL_ST_LOAD_LO = 3'd2;
localparam logic [2:0] PL_ST_CHECK   = 3'd3;
localparam logic [2:0] PL_ST_RUN     = 3'd4;
localparam logic [2:0] PL_ST_ERROR   = 3'd5;

// Number of program words in one complete load.
localparam int PL_WORD_COUNT = 32;

// 1: the high byte of each word is sent first on the byte stream.
localparam int PL_HI_FIRST = 1;

// Width of the running byte checksum.
localparam int PL_CSUM_W = 8;

// File: rtl/picoctrl_loader.sv
// rtl/picoctrl_loader.sv - program loader and reset sequencer for a PicoCTRL core
// Receives 16-bit program words as high/low byte pairs, writes them into the
// instruction RAM and releases core_res_n once the full program is loaded.
// Optional feature macro: PICOLOAD_CHECKSUM_EN (trailing checksum byte, ERROR state).
// Ports:
//   clk, res_n           - clock, asynchronous active-low reset
//   ld_start             - pulse: begin/restart a load (any state)
//   ld_valid, ld_data    - incoming program byte stream
//   ld_ready             - byte accepted this cycle when ld_valid is high
//   ld_busy, ld_err      - load in progress / checksum failure
//   core_res_n           - registered reset to the core
//   rom_addr, rom_data   - core instruction fetch port (data is 0 unless running)
module picoctrl_loader
    import picoctrl_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_err,
    output logic              core_res_n,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_data
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] word_cnt;
    logic [7:0]        hold;
    logic              xfer;
    logic              last_word;
    logic              ram_we;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;

`ifdef PICOLOAD_CHECKSUM_EN
    logic [PL_CSUM_W-1:0] csum;
    logic [PL_CSUM_W-1:0] csum_next;
    logic                 err_q;

    assign csum_next = csum + ld_data;
    assign ld_err    = err_q;
`else
    assign ld_err    = 1'b0;
`endif

    // ld_ready is a pure function of state so the source never sees a loop
    // through ld_valid.
    assign ld_ready  = (state == ST_LOAD_HI) || (state == ST_LOAD_LO) || (state == ST_CHECK);
    assign ld_busy   = ld_ready;
    assign xfer      = ld_valid && ld_ready;
    assign last_word = (word_cnt == {ADDR_W{1'b1}});

    // ld_start wins over a byte presented in the same cycle.
    assign ram_we    = (state == ST_LOAD_LO) && xfer && !ld_start;
    assign ram_wdata = {hold, ld_data};

    always_comb begin
        next_state = state;
        if (ld_start) begin
            next_state = ST_LOAD_HI;
        end else begin
            case (state)
                ST_LOAD_HI: begin
                    if (xfer) next_state = ST_LOAD_LO;
                end
                ST_LOAD_LO: begin
                    if (xfer) begin
                        if (last_word) begin
`ifdef PICOLOAD_CHECKSUM_EN
                            next_state = ST_CHECK;
`else
                            next_state = ST_RUN;
`endif
                        end else begin
                            next_state = ST_LOAD_HI;
                        end
                    end
                end
`ifdef PICOLOAD_CHECKSUM_EN
                ST_CHECK: begin
                    if (xfer) next_state = (csum_next == '0) ? ST_RUN : ST_ERROR;
                end
`endif
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= ST_IDLE;
            core_res_n <= 1'b0;
            word_cnt   <= '0;
            hold       <= '0;
`ifdef PICOLOAD_CHECKSUM_EN
            csum       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state      <= next_state;
            // Registered so the core reset edges line up with the accept edges.
            core_res_n <= (next_state == ST_RUN);
`ifdef PICOLOAD_CHECKSUM_EN
            err_q      <= (next_state == ST_ERROR);
`endif
            if (ld_start) begin
                word_cnt <= '0;
`ifdef PICOLOAD_CHECKSUM_EN
                csum     <= '0;
`endif
            end else if (xfer) begin
`ifdef PICOLOAD_CHECKSUM_EN
                csum <= csum_next;
`endif
                if (state == ST_LOAD_HI) begin
                    hold <= ld_data;
                end
                // Wraps to 0 after the last word; the FSM has left the load
                // states by then, so the wrapped value is never used.
                if (state == ST_LOAD_LO) begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    picoload_ram #(
        .ADDR_W(ADDR_W),
        .WORD_W(WORD_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(word_cnt),
        .wdata(ram_wdata),
        .raddr(rom_addr),
        .rdata(ram_rdata)
    );

    // The (possibly partial) RAM image is only exposed while running.
    assign rom_data = (state == ST_RUN) ? ram_rdata : '0;

endmodule

// File: doc/picoctrl_loader.md
# picoctrl_loader

Program loader and reset sequencer for one PicoCTRL core. It owns a 32×16 instruction RAM that replaces the fixed instruction ROM. Program words arrive over an 8-bit valid/ready byte stream. The core is held in reset until a complete program has been written, then released to run. The block sits between the system-side byte source and the core's `instruction_ROM_Addr` / `instruction_ROM_data` pins.

## Interface
Parameters:
- `ADDR_W`, default 5: instruction address width; the RAM holds 2^ADDR_W words.
- `WORD_W`, default 16: instruction width. The load protocol requires exactly 16.

Ports:
- `clk`, in, 1: single clock for all logic.
- `res_n`, in, 1: asynchronous, active-low reset.
- `ld_start`, in, 1: single-cycle pulse that begins or restarts a load. Accepted in every state.
- `ld_valid`, in, 1: `ld_data` holds a valid byte.
- `ld_data`, in, 8: program byte. High byte of each word is sent first.
- `ld_ready`, out, 1: loader accepts a byte this cycle.
- `ld_busy`, out, 1: a load is in progress.
- `ld_err`, out, 1: checksum failure (only with the checksum feature).
- `core_res_n`, out, 1: active-low reset driven to the PicoCTRL core; registered.
- `rom_addr`, in, ADDR_W: instruction address from the core.
- `rom_data`, out, WORD_W: instruction word to the core.

## Operation
- States: IDLE, LOAD_HI, LOAD_LO, CHECK (only with the checksum feature), RUN, ERROR.
- Reset values:
  - State is IDLE; `core_res_n`=0, `ld_ready`=0, `ld_busy`=0, `ld_err`=0.
  - Word counter = 0, hold byte = 0, checksum accumulator = 0.
  - RAM contents are not reset.
- `ld_start` in any state moves to LOAD_HI. On the same edge:
  - word counter ← 0, checksum ← 0, `ld_err` ← 0, `core_res_n` ← 0.
  - `ld_start` has priority over a byte transfer in the same cycle; that byte is not taken.
- `ld_ready` = 1 in LOAD_HI, LOAD_LO and CHECK; 0 otherwise. A transfer happens when `ld_valid` && `ld_ready`.
- LOAD_HI: on transfer, hold byte ← `ld_data`, go to LOAD_LO.
- LOAD_LO: on transfer:
  - RAM[word counter] ← {hold, `ld_data`}; word counter increments.
  - If the counter was 2^ADDR_W−1, go to RUN (or CHECK when the feature is compiled in). Otherwise go to LOAD_HI.
- Word counter is ADDR_W bits and wraps 31→0 on the last word. The wrap value is ignored because the FSM has already left the load states.
- Checksum: 8-bit sum, modulo 256, of every accepted byte.
- `ld_busy` = 1 in LOAD_HI, LOAD_LO and CHECK.
- `rom_data` = RAM[`rom_addr`] (asynchronous read) in RUN, and 16'h0000 in every other state.
- In RUN, extra `ld_valid` bytes are ignored (`ld_ready`=0).
- `res_n` asserted mid-load: immediate return to IDLE. The partial program stays in RAM but is never exposed; the core stays in reset until a full new load completes.

## Timing
- `core_res_n` is a flop loaded with (next_state == RUN). It rises on the same edge that accepts the final byte and falls on the same edge that accepts `ld_start`.
- A RAM write is visible on `rom_data` from the cycle after the write edge.
- `ld_ready` depends only on state, never on `ld_valid`. This avoids combinational loops with the source.
- Minimum load time is 64 cycles, or 65 with checksum, at one byte per cycle. Back-to-back transfers are supported with no bubbles.
- The core's first fetch reads address 0 on the first cycle with `core_res_n`=1.

## Configuration
- `PICOLOAD_CHECKSUM_EN` defined:
  - After the 64th byte the FSM enters CHECK and accepts one more byte.
  - If (sum of all 65 bytes) mod 256 == 0, go to RUN.
  - Otherwise go to ERROR: `ld_err`=1, `core_res_n` stays 0, `rom_data`=0. Only `ld_start` or `res_n` leaves ERROR.
- Not defined:
  - CHECK and ERROR do not exist, and the checksum accumulator is removed.
  - `ld_err` is tied to 0; RUN follows the 64th byte directly.

## Structure
- Shared include `picoload_defs.v` holds:
  - state encodings (3-bit localparams);
  - word count constant (32);
  - byte order constant (high byte first);
  - the checksum width.
- One sub-module, `picoload_ram`: parameterised RAM with ADDR_W × WORD_W, one synchronous write port and one asynchronous read port. It is instantiated once. The FSM, counter, hold register and checksum stay in the top module.

## Test plan
- **Reset:** assert `res_n`=0 mid-stream → all outputs at reset values immediately; `core_res_n`=0 and `rom_data`=0 while `rom_addr` is swept.
- **Full load:** `ld_start`, then 64 back-to-back bytes for words 0x8401+n → `core_res_n` rises on the 64th accept edge; `rom_data`=16'h8401 at `rom_addr`=0 and 16'h8420 at `rom_addr`=31.
- **Backpressure:** random `ld_valid` gaps → identical RAM contents. `ld_ready` never asserts in RUN; a stray byte 0xFF in RUN leaves RAM unchanged.
- **Restart:** `ld_start` after 20 bytes, then a full load of 0x0000..0x001F → word 0 reads 0x0000, `core_res_n` low throughout the aborted load. `ld_start` coinciding with a valid byte → that byte is dropped.
- **Restart from RUN:** `ld_start` while in RUN → `core_res_n` falls on the same edge and `rom_data` becomes 0 next cycle.
- **Checksum (`PICOLOAD_CHECKSUM_EN`):** a correct checksum byte → RUN. A checksum byte off by +1 → ERROR, `ld_err`=1, `core_res_n`=0; a following `ld_start` clears `ld_err`.
